// File: rtl/spmi_pkg.sv
// Shared constants, types and helpers for the SPMI transaction decoder.
package spmi_pkg;

  localparam logic [2:0] LEN_CMD  = 3'b110;
  localparam logic [2:0] LEN_DATA = 3'b100;

  localparam logic [7:0] EXT_WR_HI  = 8'h0F;
  localparam logic [7:0] EXT_RD_LO  = 8'h20;
  localparam logic [7:0] EXT_RD_HI  = 8'h2F;
  localparam logic [7:0] REG_WR_LO  = 8'h40;
  localparam logic [7:0] REG_RD_HI  = 8'h7F;
  localparam logic [7:0] REG0_WR_LO = 8'h80;

  localparam int unsigned ENT_ERR   = 31;
  localparam int unsigned ENT_TRUNC = 30;
  localparam int unsigned ENT_FIRST = 29;
  localparam int unsigned ENT_SID   = 24;
  localparam int unsigned ENT_CMD   = 16;
  localparam int unsigned ENT_ADDR  = 8;
  localparam int unsigned ENT_DATA  = 0;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic [1:0] {CLS_EXT, CLS_REG, CLS_REG0, CLS_OTHER} cmd_class_t;

  function automatic cmd_class_t classify(input logic [7:0] cmd);
    if (cmd >= REG0_WR_LO) return CLS_REG0;
    if (cmd >= REG_WR_LO && cmd <= REG_RD_HI) return CLS_REG;
    if (cmd <= EXT_WR_HI || (cmd >= EXT_RD_LO && cmd <= EXT_RD_HI)) return CLS_EXT;
    return CLS_OTHER;
  endfunction

  function automatic logic [31:0] make_entry(input logic err, input logic trunc,
                                             input logic first, input logic [3:0] sid,
                                             input logic [7:0] cmd, input logic [7:0] addr,
                                             input logic [7:0] data);
    logic [31:0] e;
    e = '0;
    e[ENT_ERR]        = err;
    e[ENT_TRUNC]      = trunc;
    e[ENT_FIRST]      = first;
    e[ENT_SID  +: 4]  = sid;
    e[ENT_CMD  +: 8]  = cmd;
    e[ENT_ADDR +: 8]  = addr;
    e[ENT_DATA +: 8]  = data;
    return e;
  endfunction

endpackage

// File: rtl/spmi_txn_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rd_data, zero while empty.
module spmi_txn_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  // A write into a full FIFO succeeds when the head is popped on the same edge.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_ok   = rd_en && !empty;
    wr_ok   = wr_en && (!full || rd_en);
    rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge sysclk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spmi_txn_decoder.sv
// Reassembles sniffer frame words into SPMI transactions, one FIFO entry per data byte.
// Optional parity checking is enabled by defining SPMI_DEC_PARITY_EN.
module spmi_txn_decoder #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] pkt_in,
  input  logic        pkt_valid,
  input  logic        pkt_overflow,
  output logic        pkt_fetched,
  input  logic        txn_rd,
  output logic [31:0] txn_data,
  output logic        txn_empty,
  output logic        txn_full,
  output logic [7:0]  drop_cnt,
  output logic        err_sticky
);
  import spmi_pkg::*;

  logic [2:0]  len;
  logic [12:0] frame;
  logic [3:0]  f_sid;
  logic [7:0]  f_byte;
  logic        par_bad, accept, is_cmd, is_data;
  cmd_class_t  cls;
  logic [31:0] trunc_entry, imm_entry, data_entry;

  state_t      state;
  logic [3:0]  sid_q;
  logic [7:0]  cmd_q, addr_q;
  logic [4:0]  remain_q;
  logic        cmd_err_q, first_q;
  logic        push_en, pend_en;
  logic [31:0] push_data, pend_data;

`ifdef SPMI_DEC_PARITY_EN
  assign par_bad = ~(^frame);
`else
  logic unused_parity;
  assign par_bad       = 1'b0;
  assign unused_parity = frame[0];
`endif

  always_comb begin
    len         = pkt_in[15:13];
    frame       = pkt_in[12:0];
    f_sid       = frame[12:9];
    f_byte      = frame[8:1];
    accept      = pkt_valid && !pkt_fetched;
    is_cmd      = (len == LEN_CMD);
    is_data     = (len == LEN_DATA);
    cls         = classify(f_byte);
    trunc_entry = make_entry(cmd_err_q, 1'b1, first_q, sid_q, cmd_q, addr_q, 8'h00);
    imm_entry   = make_entry(par_bad, 1'b0, 1'b1, f_sid, f_byte, 8'h00,
                             (cls == CLS_REG0) ? {1'b0, f_byte[6:0]} : 8'h00);
    data_entry  = make_entry(cmd_err_q | par_bad, 1'b0, first_q, sid_q, cmd_q, addr_q, f_byte);
  end

  // An abort followed by a zero-frame command yields two entries; the second waits in
  // pend_* for one cycle, which is free because no frame is accepted while pkt_fetched is high.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      pkt_fetched <= 1'b0;
      push_en     <= 1'b0;
      push_data   <= '0;
      pend_en     <= 1'b0;
      pend_data   <= '0;
      err_sticky  <= 1'b0;
      drop_cnt    <= '0;
      sid_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      cmd_err_q   <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      pkt_fetched <= accept;
      push_en     <= pend_en;
      push_data   <= pend_data;
      pend_en     <= 1'b0;
      if (pkt_overflow) err_sticky <= 1'b1;
      if (push_en && txn_full && !txn_rd && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (accept) begin
        if ((is_cmd || is_data) && par_bad) err_sticky <= 1'b1;
        if (is_cmd) begin
          sid_q     <= f_sid;
          cmd_q     <= f_byte;
          cmd_err_q <= par_bad;
          first_q   <= 1'b1;
          if (state != IDLE) begin
            push_en   <= 1'b1;
            push_data <= trunc_entry;
          end
          case (cls)
            CLS_EXT: begin
              state    <= ADDR;
              addr_q   <= '0;
              remain_q <= {1'b0, f_byte[3:0]} + 5'd1;
            end
            CLS_REG: begin
              state    <= DATA;
              addr_q   <= {3'b000, f_byte[4:0]};
              remain_q <= 5'd1;
            end
            default: begin
              state  <= IDLE;
              addr_q <= '0;
              if (state != IDLE) begin
                pend_en   <= 1'b1;
                pend_data <= imm_entry;
              end else begin
                push_en   <= 1'b1;
                push_data <= imm_entry;
              end
            end
          endcase
        end else if (is_data) begin
          case (state)
            IDLE: err_sticky <= 1'b1;
            ADDR: begin
              addr_q <= f_byte;
              state  <= DATA;
            end
            default: begin
              push_en   <= 1'b1;
              push_data <= data_entry;
              addr_q    <= addr_q + 8'd1;
              first_q   <= 1'b0;
              remain_q  <= remain_q - 5'd1;
              if (remain_q == 5'd1) state <= IDLE;
            end
          endcase
        end else begin
          err_sticky <= 1'b1;
        end
      end
    end
  end

  spmi_txn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .sysclk  (sysclk),
    .reset   (reset),
    .wr_en   (push_en),
    .wr_data (push_data),
    .rd_en   (txn_rd),
    .rd_data (txn_data),
    .empty   (txn_empty),
    .full    (txn_full)
  );

endmodule

// File: tb/tb_spmi_txn_decoder.sv
// Directed and randomized bench for spmi_txn_decoder against a transaction-level model.
module tb_spmi_txn_decoder;
  localparam int DEPTH = 16;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pkt_in = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_overflow = 1'b0;
  logic        txn_rd = 1'b0;
  logic        pkt_fetched;
  logic [31:0] txn_data;
  logic        txn_empty, txn_full, err_sticky;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int fetch_cnt = 0;

  logic [31:0] exp_q[$];
  int          m_drops;
  bit          m_sticky, m_busy, m_need_addr, m_cerr, m_first;
  int          m_left;
  logic [3:0]  m_sid;
  logic [7:0]  m_cmd, m_addr;

  spmi_txn_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .pkt_in       (pkt_in),
    .pkt_valid    (pkt_valid),
    .pkt_overflow (pkt_overflow),
    .pkt_fetched  (pkt_fetched),
    .txn_rd       (txn_rd),
    .txn_data     (txn_data),
    .txn_empty    (txn_empty),
    .txn_full     (txn_full),
    .drop_cnt     (drop_cnt),
    .err_sticky   (err_sticky)
  );

  always #5 sysclk = ~sysclk;
  always @(negedge sysclk) if (pkt_fetched) fetch_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit pbad(input logic [12:0] f);
`ifdef SPMI_DEC_PARITY_EN
    return (^f) == 1'b0;
`else
    return (f == 13'h0) && (f != 13'h0);
`endif
  endfunction

  function automatic logic [15:0] mk_cmd(input logic [3:0] sid, input logic [7:0] cmd, input bit bad);
    logic [12:0] f;
    f = {sid, cmd, 1'b0};
    f[0] = ~(^f[12:1]) ^ bad;
    return {3'b110, f};
  endfunction

  function automatic logic [15:0] mk_data(input logic [7:0] b, input bit bad);
    logic [12:0] f;
    f = {4'h0, b, 1'b0};
    f[0] = ~(^f[12:1]) ^ bad;
    return {3'b100, f};
  endfunction

  task automatic m_reset();
    exp_q.delete();
    m_drops = 0; m_sticky = 0; m_busy = 0; m_need_addr = 0; m_left = 0;
    m_cerr = 0; m_first = 0; m_sid = '0; m_cmd = '0; m_addr = '0;
  endtask

  task automatic m_emit(input bit e, input bit t, input bit f, input logic [3:0] s,
                        input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back({e, t, f, 1'b0, s, c, a, d});
    else if (m_drops < 255) m_drops++;
  endtask

  task automatic m_pop();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic m_frame(input logic [15:0] w);
    logic [12:0] f;
    bit pb;
    int c;
    f = w[12:0];
    pb = pbad(f);
    if (w[15:13] == 3'b110) begin
      if (pb) m_sticky = 1;
      if (m_busy) m_emit(m_cerr, 1, m_first, m_sid, m_cmd, m_addr, 8'h00);
      m_sid = f[12:9]; m_cmd = f[8:1]; m_cerr = pb; m_first = 1; m_addr = 8'h00; m_busy = 0;
      c = int'(m_cmd);
      if (c >= 128) m_emit(pb, 0, 1, m_sid, m_cmd, 8'h00, 8'(c - 128));
      else if (c >= 64) begin m_busy = 1; m_need_addr = 0; m_left = 1; m_addr = 8'(c % 32); end
      else if (c < 16 || (c >= 32 && c < 48)) begin m_busy = 1; m_need_addr = 1; m_left = c % 16 + 1; end
      else m_emit(pb, 0, 1, m_sid, m_cmd, 8'h00, 8'h00);
    end else if (w[15:13] == 3'b100) begin
      if (pb) m_sticky = 1;
      if (!m_busy) m_sticky = 1;
      else if (m_need_addr) begin m_addr = f[8:1]; m_need_addr = 0; end
      else begin
        m_emit(m_cerr | pb, 0, m_first, m_sid, m_cmd, m_addr, f[8:1]);
        m_addr = m_addr + 8'd1; m_first = 0; m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else begin
      m_sticky = 1;
    end
  endtask

  // Presents one frame, waits (bounded) for the fetch pulse; optionally pops alongside the push.
  task automatic send(input logic [15:0] w, input bit pop_too);
    int n;
    @(negedge sysclk);
    pkt_in = w; pkt_valid = 1'b1; n = 0;
    do begin @(negedge sysclk); n++; end while (!pkt_fetched && n < 8);
    pkt_valid = 1'b0;
    check("fetch_pulse", pkt_fetched, 1'b1);
    if (pop_too) begin m_pop(); txn_rd = 1'b1; end
    m_frame(w);
    if (pop_too) begin @(negedge sysclk); txn_rd = 1'b0; end
  endtask

  task automatic drain();
    logic [31:0] e;
    repeat (3) @(negedge sysclk);
    check("full_flag", txn_full, exp_q.size() == DEPTH);
    check("err_sticky", err_sticky, m_sticky);
    check("drop_cnt", drop_cnt, m_drops);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("entry", txn_data, e);
      txn_rd = 1'b1;
      @(negedge sysclk);
    end
    txn_rd = 1'b0;
    check("empty_after_drain", txn_empty, 1'b1);
  endtask

  task automatic check_reset_values();
    check("rst_fetched", pkt_fetched, 1'b0);
    check("rst_empty", txn_empty, 1'b1);
    check("rst_full", txn_full, 1'b0);
    check("rst_drop", drop_cnt, 8'h00);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_data", txn_data, 32'h0);
  endtask

  initial begin
    int f0;
    int r;
    logic [7:0] cmd;
    logic [15:0] w;
    logic [2:0] lens[6];
    lens = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b111};

    m_reset();
    repeat (3) @(negedge sysclk);
    check_reset_values();
    reset = 1'b0;

    // Reg write with latency and fetch count
    f0 = fetch_cnt;
    send(16'hC48B, 0);
    send(16'h814B, 0);
    check("lat_n1_empty", txn_empty, 1'b1);
    @(negedge sysclk);
    check("lat_n2_empty", txn_empty, 1'b0);
    check("reg_wr_head", txn_data, 32'h224505A5);
    check("reg_wr_fetches", fetch_cnt - f0, 2);
    drain();

    // Ext write with address wrap
    send(mk_cmd(4'h1, 8'h01, 0), 0);
    send(mk_data(8'hFF, 0), 0);
    send(mk_data(8'h11, 0), 0);
    send(mk_data(8'h22, 0), 0);
    drain();

    // Parity error on the data frame
    send(16'hC48B, 0);
    send(16'h814A, 0);
    repeat (3) @(negedge sysclk);
`ifdef SPMI_DEC_PARITY_EN
    check("par_head", txn_data, 32'hA24505A5);
`else
    check("par_head", txn_data, 32'h224505A5);
`endif
    drain();

    // Truncated ext read, then a new reg write and an abort into a zero-frame command
    send(mk_cmd(4'h3, 8'h23, 0), 0);
    send(mk_data(8'h40, 0), 0);
    send(16'hC48B, 0);
    send(16'h814B, 0);
    send(mk_cmd(4'h9, 8'h02, 0), 0);
    send(mk_cmd(4'hA, 8'hC5, 0), 0);
    drain();

    // Fill past full, then push+pop while full and push+pop while empty
    for (int i = 0; i < DEPTH + 3; i++) send(mk_cmd(4'(i), 8'h80 | 8'(i), 0), 0);
    repeat (3) @(negedge sysclk);
    check("full_set", txn_full, 1'b1);
    check("drops_after_fill", drop_cnt, m_drops);
    send(mk_cmd(4'h5, 8'hC0, 0), 1);
    drain();
    send(mk_cmd(4'h6, 8'h81, 0), 1);
    drain();

    // Held valid yields one fetch
    f0 = fetch_cnt;
    @(negedge sysclk);
    w = mk_cmd(4'h7, 8'h9A, 0);
    pkt_in = w; pkt_valid = 1'b1;
    repeat (2) @(negedge sysclk);
    pkt_valid = 1'b0;
    m_frame(w);
    repeat (2) @(negedge sysclk);
    check("hold_fetches", fetch_cnt - f0, 1);
    drain();

    // Overflow, then reset in the middle of an ext write
    @(negedge sysclk); pkt_overflow = 1'b1;
    @(negedge sysclk); pkt_overflow = 1'b0; m_sticky = 1;
    @(negedge sysclk);
    check("overflow_sticky", err_sticky, 1'b1);
    send(mk_cmd(4'h8, 8'h03, 0), 0);
    send(mk_data(8'h10, 0), 0);
    send(mk_data(8'hAA, 0), 0);
    send(mk_data(8'hBB, 0), 0);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);
    check_reset_values();
    reset = 1'b0;
    m_reset();
    send(mk_data(8'h55, 0), 0);
    drain();

    // Randomized frames
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        case ($urandom_range(0, 3))
          0: cmd = {2'b00, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 3))};
          1: cmd = 8'h40 + 8'($urandom_range(0, 63));
          2: cmd = 8'h80 | 8'($urandom);
          default: cmd = ($urandom_range(0, 1) ? 8'h10 : 8'h30) + 8'($urandom_range(0, 15));
        endcase
        w = mk_cmd(4'($urandom), cmd, $urandom_range(0, 19) == 0);
      end else if (r < 90) begin
        w = mk_data(8'($urandom), $urandom_range(0, 19) == 0);
      end else begin
        w = {lens[$urandom_range(0, 5)], 13'($urandom)};
      end
      send(w, $urandom_range(0, 9) == 0);
      if (exp_q.size() >= 12 && $urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
